// File: rtl/instr_encoder.sv
// RV32I instruction encoder for R/LW/SW/BEQ/BGE/ADDI with a small output FIFO.
// Illegal or out-of-range requests are accepted, dropped and reported on err one cycle later.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_class,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OccFull = (AW + 1)'(DEPTH);

  localparam logic [2:0] OpR    = 3'd0;
  localparam logic [2:0] OpLw   = 3'd1;
  localparam logic [2:0] OpSw   = 3'd2;
  localparam logic [2:0] OpBeq  = 3'd3;
  localparam logic [2:0] OpBge  = 3'd4;
  localparam logic [2:0] OpAddi = 3'd5;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;

  // Encoder
  logic        imm12_ok;
  logic        br_ok;
  logic        legal;
  logic [31:0] word;

  // A value fits in N signed bits when all bits from N-1 upward agree.
  assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign br_ok    = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op_class)
      OpR: begin
        word  = {funct7, rs2, rs1, funct3, rd, OpcR};
        legal = 1'b1;
      end
      OpLw: begin
        word  = {imm[11:0], rs1, 3'b010, rd, OpcLoad};
        legal = imm12_ok;
      end
      OpSw: begin
        word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OpcStore};
        legal = imm12_ok;
      end
      OpBeq: begin
        word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OpcBranch};
        legal = br_ok;
      end
      OpBge: begin
        word  = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], OpcBranch};
        legal = br_ok;
      end
      OpAddi: begin
        word  = {imm[11:0], rs1, 3'b000, rd, OpcImm};
        legal = imm12_ok;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // FIFO
  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;

  assign full     = (occ_q == OccFull);
  assign empty    = (occ_q == '0);
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = ~empty & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    err_d    = accept & ~legal;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW + 1)'(1);
      2'b01:   occ_d = occ_q - (AW + 1)'(1);
      default: occ_d = occ_q;
    endcase
    if (push && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign out_valid = ~empty;
  assign out_instr = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of single-instruction vectors plus
// hand-written sequences for streaming, backpressure/full and mid-run reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_class;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_class  (op_class),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        err;
    logic [31:0] instr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1;
    op_class = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    funct3   = 3'd0;
    funct7   = 7'd0;
    imm      = im;
  endtask

  function automatic logic [31:0] addi_word(input logic [4:0] d, input logic [11:0] im);
    return {im, 5'd0, 3'b000, d, 7'b0010011};
  endfunction

  int exp_count;

  initial begin
    vecs[0]  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         1'b0, 32'h002081B3};
    vecs[1]  = '{3'd1, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8,         1'b0, 32'h00812283};
    vecs[2]  = '{3'd2, 5'd0, 5'd2, 5'd5, 3'd0, 7'd0, 32'hFFFFFFFC,  1'b0, 32'hFE512E23};
    vecs[3]  = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF,  1'b0, 32'hFFF00093};
    vecs[4]  = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         1'b0, 32'h00208463};
    vecs[5]  = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC,  1'b0, 32'hFE20DEE3};
    vecs[6]  = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         1'b1, 32'h0};
    vecs[7]  = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      1'b1, 32'h0};
    vecs[8]  = '{3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,         1'b1, 32'h0};
    vecs[9]  = '{3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,         1'b1, 32'h0};
    vecs[10] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      1'b0, 32'h7FF00093};
    vecs[11] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,  1'b0, 32'h80000093};
    vecs[12] = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094,      1'b0, 32'h7E208FE3};
    vecs[13] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000,  1'b0, 32'h8020D063};
    vecs[14] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,      1'b1, 32'h0};
    vecs[15] = '{3'd1, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF,  1'b1, 32'h0};
    vecs[16] = '{3'd2, 5'd0, 5'd2, 5'd5, 3'd0, 7'd0, 32'd2047,      1'b0, 32'h7E512FA3};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    exp_count = 0;

    // Single-instruction vectors, consumer always ready.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      funct3 = vecs[i].f3;
      funct7 = vecs[i].f7;
      @(negedge clk);
      in_valid = 1'b0;
      if (!vecs[i].err) exp_count++;
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(!vecs[i].err));
      if (!vecs[i].err) chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(exp_count));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_err_gone", i), 32'(err), 32'd0);
      chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back stream: push and pop on the same edge keep order.
    for (int i = 1; i <= 4; i++) begin
      drive(3'd5, 5'd4, 5'd0, 5'd0, 32'(i * 16));
      @(negedge clk);
      exp_count++;
      chk($sformatf("stream%0d_instr", i), out_instr, addi_word(5'd4, 12'(i * 16)));
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_count", 32'(count), 32'(exp_count));

    // Backpressure: 5 requests offered, only 4 fit.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'(i <= 4));
      drive(3'd5, 5'd1, 5'd0, 5'd0, 32'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    exp_count += 4;
    chk("full_count", 32'(count), 32'(exp_count));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("hold_instr", out_instr, addi_word(5'd1, 12'd1));
    chk("hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_instr", i), out_instr, addi_word(5'd1, 12'(i)));
      @(negedge clk);
      chk($sformatf("drain%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Reset with three words queued.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(3'd5, 5'd3, 5'd0, 5'd0, 32'(100 + i));
      @(negedge clk);
    end
    drive(3'd5, 5'd0, 5'd0, 5'd0, 32'd4000);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    drive(3'd5, 5'd2, 5'd0, 5'd0, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst2_head", out_instr, 32'h00700113);
    chk("rst2_count1", 32'(count), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_alone", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
